// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, LSB-first data, optional parity, stop bits
module uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_serial,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_WIDTH);

    localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic          ODD_BIT   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           baud_cnt, baud_nxt;
    logic [BW-1:0]           bit_cnt, bit_nxt;
    logic [DATA_WIDTH-1:0]   shift_reg, shift_nxt;
    logic                    parity_bit, parity_nxt;
    logic                    serial_nxt;
    logic                    done_nxt;
    logic                    tick;

    assign tick = (baud_cnt == LAST_TICK);

    // Next-state, counters and the next registered line level.
    // A new word is also taken on the edge that ends the last stop bit so
    // consecutive frames leave no idle gap on the line.
    always_comb begin
        state_nxt  = state;
        baud_nxt   = tick ? '0 : baud_cnt + 1'b1;
        bit_nxt    = bit_cnt;
        shift_nxt  = shift_reg;
        parity_nxt = parity_bit;
        done_nxt   = 1'b0;
        serial_nxt = 1'b1;

        case (state)
            IDLE: begin
                baud_nxt = '0;
                if (tx_valid) begin
                    state_nxt  = START;
                    shift_nxt  = tx_data;
                    parity_nxt = (^tx_data) ^ ODD_BIT;
                end
            end
            START: begin
                if (tick) begin
                    state_nxt = DATA;
                    bit_nxt   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_nxt = shift_reg >> 1;
                    if (bit_cnt == LAST_DATA) begin
                        state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                        bit_nxt   = '0;
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_nxt = STOP;
                    bit_nxt   = '0;
                end
            end
            STOP: begin
                if (tick) begin
                    if (bit_cnt == LAST_STOP) begin
                        done_nxt = 1'b1;
                        if (tx_valid) begin
                            state_nxt  = START;
                            shift_nxt  = tx_data;
                            parity_nxt = (^tx_data) ^ ODD_BIT;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                baud_nxt  = '0;
            end
        endcase

        case (state_nxt)
            START:   serial_nxt = 1'b0;
            DATA:    serial_nxt = shift_nxt[0];
            PARITY:  serial_nxt = parity_bit;
            default: serial_nxt = 1'b1;
        endcase
    end

    // State, datapath and registered outputs; reset forces the line idle at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            tx_serial  <= 1'b1;
            tx_ready   <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state      <= state_nxt;
            baud_cnt   <= baud_nxt;
            bit_cnt    <= bit_nxt;
            shift_reg  <= shift_nxt;
            parity_bit <= parity_nxt;
            tx_serial  <= serial_nxt;
            tx_ready   <= (state_nxt == IDLE);
            tx_busy    <= (state_nxt != IDLE);
            tx_done    <= done_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed bench for uart_tx with a scoreboarded line receiver
module tb_uart_tx;

    logic       clk;
    logic       reset;
    logic [7:0] dat [4];
    logic       vld [4];
    logic       rdy [4];
    logic       ser [4];
    logic       bsy [4];
    logic       dn  [4];

    int n_cmp  = 0;
    int n_bad  = 0;
    int rx_frames = 0;
    int done_cnt [4];

    typedef struct {
        int         idx;
        logic [7:0] data;
    } sb_t;
    sb_t sb[$];

    time e0_t;

    // 0: 8N1, 1: 8E1, 2: 8O1, 3: 8N2; all 16 clocks per bit
    uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .reset(reset), .tx_data(dat[0]), .tx_valid(vld[0]),
        .tx_ready(rdy[0]), .tx_serial(ser[0]), .tx_busy(bsy[0]), .tx_done(dn[0]));
    uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .reset(reset), .tx_data(dat[1]), .tx_valid(vld[1]),
        .tx_ready(rdy[1]), .tx_serial(ser[1]), .tx_busy(bsy[1]), .tx_done(dn[1]));
    uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(16), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .reset(reset), .tx_data(dat[2]), .tx_valid(vld[2]),
        .tx_ready(rdy[2]), .tx_serial(ser[2]), .tx_busy(bsy[2]), .tx_done(dn[2]));
    uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_8n2 (
        .clk(clk), .reset(reset), .tx_data(dat[3]), .tx_valid(vld[3]),
        .tx_ready(rdy[3]), .tx_serial(ser[3]), .tx_busy(bsy[3]), .tx_done(dn[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pen(input int i);
        return (i == 1 || i == 2) ? 1 : 0;
    endfunction

    function automatic int nbits(input int i);
        return 10 + pen(i) + ((i == 3) ? 1 : 0);
    endfunction

    function automatic logic frame_bit(input int i, input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (pen(i) == 1 && b == 9) return (^d) ^ (i == 2);
        return 1'b1;
    endfunction

    function automatic logic [3:0] st(input int i);
        return {ser[i], rdy[i], bsy[i], dn[i]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line receiver: samples mid-bit and compares whole frames against the scoreboard.
    initial begin
        bit          rx_act [4];
        int          rx_cnt [4];
        logic [15:0] rx_vec [4];
        logic [15:0] ev;
        sb_t         e;
        int          b;
        for (int i = 0; i < 4; i++) begin
            rx_act[i] = 0; rx_cnt[i] = 0; rx_vec[i] = '0; done_cnt[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (dn[i] === 1'b1) done_cnt[i]++;
                if (reset) begin
                    rx_act[i] = 0;
                end else if (!rx_act[i]) begin
                    if (ser[i] === 1'b0) begin
                        rx_act[i] = 1; rx_cnt[i] = 0; rx_vec[i] = '0;
                    end
                end else begin
                    rx_cnt[i]++;
                end
                if (!reset && rx_act[i] && (rx_cnt[i] % 16) == 8) begin
                    b = rx_cnt[i] / 16;
                    rx_vec[i][b] = ser[i];
                    if (b == nbits(i) - 1) begin
                        rx_act[i] = 0;
                        if (sb.size() == 0) begin
                            check("sb_unexpected_frame", 32'd1, 32'd0);
                        end else begin
                            e = sb.pop_front();
                            ev = '0;
                            for (int k = 0; k < nbits(i); k++) ev[k] = frame_bit(i, e.data, k);
                            check("sb_instance", i, e.idx);
                            check("sb_frame", {16'h0, rx_vec[i]}, {16'h0, ev});
                            rx_frames++;
                        end
                    end
                end
            end
            if (reset) sb.delete();
        end
    end

    task automatic send(input int i, input logic [7:0] d, input bit keep);
        int n;
        @(posedge clk); #2;
        dat[i] = d;
        vld[i] = 1'b1;
        n = 0;
        while (rdy[i] !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n == 500) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        e0_t = $time;
        sb.push_back('{idx: i, data: d});
        #2;
        if (!keep) vld[i] = 1'b0;
    endtask

    // Checks every cycle of one frame against the model, starting at the negedge after acceptance.
    task automatic watch_frame(input int i, input logic [7:0] d, input int nc,
                               input logic first_done, input string tag, output logic par_lvl);
        int bad_ser = 0;
        int bad_rdy = 0;
        int bad_done = 0;
        par_lvl = 1'bx;
        for (int k = 0; k < nc; k++) begin
            @(negedge clk);
            if (ser[i] !== frame_bit(i, d, k / 16)) bad_ser++;
            if (rdy[i] !== 1'b0 || bsy[i] !== 1'b1) bad_rdy++;
            if (dn[i] !== ((k == 0) ? first_done : 1'b0)) bad_done++;
            if (k == 9 * 16 + 8) par_lvl = ser[i];
        end
        check({tag, "_line"}, bad_ser, 0);
        check({tag, "_busy"}, bad_rdy, 0);
        check({tag, "_done"}, bad_done, 0);
    endtask

    task automatic end_check(input int i, input string tag);
        @(negedge clk);
        check({tag, "_end"}, st(i), 4'b1101);
        @(negedge clk);
        check({tag, "_after"}, st(i), 4'b1100);
    endtask

    task automatic idle_watch(input int i, input int n, input string tag);
        int bad = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (st(i) !== 4'b1100) bad++;
        end
        check(tag, bad, 0);
    endtask

    initial begin
        logic p;
        int   dc;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dat[i] = 8'h00;
            vld[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) check($sformatf("reset_state_%0d", i), st(i), 4'b1100);
        @(posedge clk); #2;
        reset = 1'b0;

        // 8N1 0xA5: done at cycle 160, ready low before it
        send(0, 8'hA5, 0);
        watch_frame(0, 8'hA5, 160, 1'b0, "a5", p);
        end_check(0, "a5");

        // even parity 0x07 -> parity bit 1, 176-cycle frame
        send(1, 8'h07, 0);
        watch_frame(1, 8'h07, 176, 1'b0, "even", p);
        check("even_parity_bit", p, 1'b1);
        end_check(1, "even");

        // odd parity 0x07 -> parity bit 0
        send(2, 8'h07, 0);
        watch_frame(2, 8'h07, 176, 1'b0, "odd", p);
        check("odd_parity_bit", p, 1'b0);
        end_check(2, "odd");

        // back-to-back 0x00 then 0xFF with tx_valid held
        send(0, 8'h00, 1);
        dat[0] = 8'hFF;
        watch_frame(0, 8'h00, 160, 1'b0, "b2b_first", p);
        sb.push_back('{idx: 0, data: 8'hFF});
        fork
            watch_frame(0, 8'hFF, 160, 1'b1, "b2b_second", p);
            begin
                @(posedge clk); #2;
                vld[0] = 1'b0;
            end
        join
        end_check(0, "b2b");

        // reset during data bit 3 of 0x55
        dc = done_cnt[0];
        send(0, 8'h55, 0);
        repeat (71) @(negedge clk);
        check("pre_reset_low", ser[0], 1'b0);
        #2 reset = 1'b1;
        #1 check("reset_immediate", st(0), 4'b1100);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        idle_watch(0, 120, "post_reset_idle");
        check("no_done_after_abort", done_cnt[0], dc);
        send(0, 8'h3C, 0);
        watch_frame(0, 8'h3C, 160, 1'b0, "x3c", p);
        end_check(0, "x3c");

        // requests while busy are ignored and tx_data changes do not leak in
        send(0, 8'h81, 0);
        fork
            watch_frame(0, 8'h81, 160, 1'b0, "x81", p);
            begin
                for (int j = 0; j < 6; j++) begin
                    repeat (15) @(posedge clk);
                    #2;
                    dat[0] = 8'($urandom);
                    vld[0] = 1'b1;
                    @(posedge clk); #2;
                    vld[0] = 1'b0;
                end
            end
        join
        end_check(0, "x81");
        idle_watch(0, 200, "x81_no_extra_frame");

        // 8N2: 32-cycle stop interval, done at cycle 176
        send(3, 8'hC3, 0);
        watch_frame(3, 8'hC3, 176, 1'b0, "n2", p);
        end_check(3, "n2");

        repeat (20) @(negedge clk);
        check("frames_received", rx_frames, 8);
        check("scoreboard_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
